mac_sequencer: RTL and testbench
================================

Name: mac_sequencer

Overview:
- Multi-cycle multiply-accumulate controller built around exactly one shared adder_8_bit instance.
- Accepts an 8x8 unsigned operand pair over a valid/ready handshake.
- Forms the 16-bit product by shift-and-add, then adds it into a 16-bit accumulator in three 8-bit passes.
- Top-level sequencer of the MAC unit. All additions go through the single adder; there are no other `+` operators.

Parameters:
- ACC_INIT, 16'h0000, value loaded into acc on reset and on acc_clear.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- a  input  8  multiplicand, unsigned
- b  input  8  multiplier, unsigned
- in_valid  input  1  operand pair valid
- in_ready  output  1  high only in IDLE; transfer occurs when in_valid & in_ready at a rising edge
- acc_clear  input  1  load ACC_INIT into acc; sampled only in IDLE
- acc  output  16  accumulator value; stable in IDLE and DONE
- out_valid  output  1  one-cycle pulse when acc holds the new sum
- busy  output  1  high in every state except IDLE
- overflow  output  1  sticky accumulator overflow flag (see Optional Feature)

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset values: state=IDLE, acc=ACC_INIT, out_valid=0, busy=0, overflow=0, in_ready=1 once rst deasserts. Internal registers hi, lo, mcand, cnt, c1 are all cleared.
- States: IDLE -> MUL (8 cycles) -> ACC_LO -> ACC_HI -> ACC_CY -> DONE -> IDLE.
- IDLE, on transfer: load mcand<=a, lo<=b, hi<=0, cnt<=0, then go to MUL.
- IDLE, acc_clear: acc<=ACC_INIT and overflow<=0.
  - If acc_clear coincides with a transfer, the clear applies first and the new product accumulates onto ACC_INIT.
  - acc_clear outside IDLE is ignored.
- MUL, each cycle:
  - If lo[0]=1: adder operands = (hi, mcand), c = carry_out.
  - Otherwise: sum = hi, c = 0.
  - Update {hi,lo} <= {c, sum, lo[7:1]} and cnt<=cnt+1.
  - Leave MUL after cnt=7. {hi,lo} now equals a*b.
- ACC_LO: adder(acc[7:0], lo); acc[7:0]<=sum; c1<=carry_out.
- ACC_HI: adder(acc[15:8], hi); acc[15:8]<=sum; c2 = carry_out.
- ACC_CY: adder(acc[15:8], {7'b0,c1}); acc[15:8]<=sum; c3 = carry_out. This state always runs, so latency is fixed.
- DONE: out_valid=1 for this cycle only, then go to IDLE.
- Latency: transfer at edge k gives MUL during cycles k+1..k+8, ACC_LO k+9, ACC_HI k+10, ACC_CY k+11, and out_valid high in cycle k+12.
  - Earliest next transfer is the edge ending cycle k+13, so throughput is one op per 13 cycles.
- Arithmetic: the product is exact (max 65025). acc wraps modulo 2^16; no saturation.
- Adder sharing: the adder operands are muxed by state. In IDLE and DONE the operands are driven to 0, so its output is don't-care.
- Reset mid-operation: the in-flight op is dropped, no out_valid is produced, acc returns to ACC_INIT, and the next transfer is accepted normally.
- in_valid while busy: not accepted. The upstream must hold a and b until the transfer.

Optional Feature:
- Macro MAC_OVERFLOW_FLAG_EN.
- Defined: overflow is set (sticky) when c2|c3 = 1 in ACC_HI or ACC_CY. It is cleared only by rst or acc_clear.
- Undefined: overflow is tied to 0, and c2/c3 are unused.
- The port exists in both builds.

Test Plan:
1. Reset, then transfer a=3, b=5 -> in_ready=0 and busy=1 for 12 cycles; out_valid pulses 12 cycles after the transfer edge with acc=15; in_ready=1 the next cycle.
2. Continue from acc=15, transfer a=255, b=255 -> acc=65040, overflow=0.
3. Continue, transfer a=255, b=2 -> acc=14 (65550 mod 2^16). overflow=1 if MAC_OVERFLOW_FLAG_EN is defined, else 0. Then acc_clear alone in IDLE -> acc=0, overflow=0.
4. acc_clear together with a transfer of a=16, b=16 while acc=1000 -> acc=256. Also: acc_clear pulsed during MUL is ignored, so acc after DONE is still 256 (then a=0, b=0).
5. Transfer a=0, b=200 with acc=77 -> latency still 12 cycles, acc=77. Also: in_valid held high during busy produces no extra transfer (count exactly one out_valid).
6. Transfer a=9, b=9, then assert rst asynchronously in MUL cycle 4 -> acc=ACC_INIT immediately and no out_valid; after release in_ready=1, and a=2, b=3 gives acc=6.

Source files
------------

// File: rtl/mac_sequencer.sv
// mac_sequencer: 8x8 shift-and-add multiply, then a 16-bit accumulate done in
// three 8-bit passes, with every addition sharing one adder_8_bit instance.
// Optional build macro MAC_OVERFLOW_FLAG_EN enables the sticky overflow flag;
// when it is undefined the overflow port stays low.

module adder_8_bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] sum,
    output logic       carry_out
);
    // Plain 8-bit unsigned add with carry out
    assign {carry_out, sum} = 9'(a) + 9'(b);
endmodule

module mac_sequencer #(
    parameter logic [15:0] ACC_INIT = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        acc_clear,
    output logic [15:0] acc,
    output logic        out_valid,
    output logic        busy,
    output logic        overflow
);
    localparam int unsigned CNT_W = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_ACC_LO,
        S_ACC_HI,
        S_ACC_CY,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        acc_q, acc_d;
    logic [7:0]         hi_q, hi_d;
    logic [7:0]         lo_q, lo_d;
    logic [7:0]         mcand_q, mcand_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               c1_q, c1_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;
    logic               in_ready_q, in_ready_d;
    logic               overflow_q, overflow_d;

    logic [7:0]         add_a, add_b, add_sum;
    logic               add_co;
    logic [7:0]         mul_sum;
    logic               mul_c;

    adder_8_bit u_adder (
        .a         (add_a),
        .b         (add_b),
        .sum       (add_sum),
        .carry_out (add_co)
    );

    // Steer the shared adder operands by state; idle states feed zeros
    always_comb begin
        add_a = 8'h00;
        add_b = 8'h00;
        case (state_q)
            S_MUL: begin
                if (lo_q[0]) begin
                    add_a = hi_q;
                    add_b = mcand_q;
                end
            end
            S_ACC_LO: begin
                add_a = acc_q[7:0];
                add_b = lo_q;
            end
            S_ACC_HI: begin
                add_a = acc_q[15:8];
                add_b = hi_q;
            end
            S_ACC_CY: begin
                add_a = acc_q[15:8];
                add_b = {7'b0, c1_q};
            end
            default: ;
        endcase
    end

    // Partial-product step: add multiplicand only when the current multiplier bit is set
    always_comb begin
        mul_sum = hi_q;
        mul_c   = 1'b0;
        if (lo_q[0]) begin
            mul_sum = add_sum;
            mul_c   = add_co;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        mcand_d    = mcand_q;
        cnt_d      = cnt_q;
        c1_d       = c1_q;
`ifdef MAC_OVERFLOW_FLAG_EN
        overflow_d = overflow_q;
`else
        overflow_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (acc_clear) begin
                    acc_d      = ACC_INIT;
                    overflow_d = 1'b0;
                end
                if (in_valid) begin
                    mcand_d = a;
                    lo_d    = b;
                    hi_d    = 8'h00;
                    cnt_d   = '0;
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                hi_d  = {mul_c, mul_sum[7:1]};
                lo_d  = {mul_sum[0], lo_q[7:1]};
                cnt_d = CNT_W'(cnt_q + CNT_W'(1));
                if (cnt_q == CNT_W'(7)) begin
                    state_d = S_ACC_LO;
                end
            end
            S_ACC_LO: begin
                acc_d[7:0] = add_sum;
                c1_d       = add_co;
                state_d    = S_ACC_HI;
            end
            S_ACC_HI: begin
                acc_d[15:8] = add_sum;
`ifdef MAC_OVERFLOW_FLAG_EN
                if (add_co) overflow_d = 1'b1;
`endif
                state_d     = S_ACC_CY;
            end
            S_ACC_CY: begin
                acc_d[15:8] = add_sum;
`ifdef MAC_OVERFLOW_FLAG_EN
                if (add_co) overflow_d = 1'b1;
`endif
                state_d     = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        out_valid_d = (state_d == S_DONE);
        busy_d      = (state_d != S_IDLE);
        in_ready_d  = (state_d == S_IDLE);
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            acc_q       <= ACC_INIT;
            hi_q        <= 8'h00;
            lo_q        <= 8'h00;
            mcand_q     <= 8'h00;
            cnt_q       <= '0;
            c1_q        <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            mcand_q     <= mcand_d;
            cnt_q       <= cnt_d;
            c1_q        <= c1_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            in_ready_q  <= in_ready_d;
            overflow_q  <= overflow_d;
        end
    end

    assign acc       = acc_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign in_ready  = in_ready_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer; expected accumulator values are hand-computed.
// Build with MAC_OVERFLOW_FLAG_EN defined to expect the sticky overflow flag.

module tb_mac_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  a, b;
    logic        in_valid, acc_clear;
    logic        in_ready, out_valid, busy, overflow;
    logic [15:0] acc;

    int n_total = 0;
    int n_pass  = 0;

`ifdef MAC_OVERFLOW_FLAG_EN
    localparam logic OVF_EN = 1'b1;
`else
    localparam logic OVF_EN = 1'b0;
`endif

    mac_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .acc_clear (acc_clear),
        .acc       (acc),
        .out_valid (out_valid),
        .busy      (busy),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One operation: called 1ns after an edge while idle; returns 1ns after the edge following DONE
    task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                          input logic clr, input logic hold, input logic clr_mid,
                          input logic [15:0] exp_acc, input logic exp_ovf);
        int  lat;
        bit  ok;
        a         = ta;
        b         = tb;
        in_valid  = 1'b1;
        acc_clear = clr;
        tick();
        if (!hold) in_valid = 1'b0;
        acc_clear = 1'b0;
        lat = 1;
        ok  = 1'b1;
        while (out_valid !== 1'b1 && lat < 40) begin
            if (busy !== 1'b1 || in_ready !== 1'b0) ok = 1'b0;
            acc_clear = (clr_mid && lat == 3);
            tick();
            lat++;
        end
        acc_clear = 1'b0;
        check_eq({tag, "_latency"}, 32'(lat), 32'd12);
        check_eq({tag, "_busy_window"}, 32'(ok), 32'd1);
        check_eq({tag, "_busy_done"}, 32'(busy), 32'd1);
        check_eq({tag, "_acc"}, 32'(acc), 32'(exp_acc));
        check_eq({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
        tick();
        in_valid = 1'b0;
        check_eq({tag, "_ov_drop"}, 32'(out_valid), 32'd0);
        check_eq({tag, "_ready_after"}, 32'(in_ready), 32'd1);
        check_eq({tag, "_acc_stable"}, 32'(acc), 32'(exp_acc));
    endtask

    initial begin
        int pulses;
        rst       = 1'b1;
        a         = 8'h00;
        b         = 8'h00;
        in_valid  = 1'b0;
        acc_clear = 1'b0;
        #12;
        check_eq("rst_acc", 32'(acc), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_overflow", 32'(overflow), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);

        // 1-3: accumulate, wrap, clear
        run_op("t1", 8'd3, 8'd5, 1'b0, 1'b0, 1'b0, 16'd15, 1'b0);
        run_op("t2", 8'd255, 8'd255, 1'b0, 1'b0, 1'b0, 16'd65040, 1'b0);
        run_op("t3", 8'd255, 8'd2, 1'b0, 1'b0, 1'b0, 16'd14, OVF_EN);
        acc_clear = 1'b1;
        tick();
        acc_clear = 1'b0;
        check_eq("t3_clear_acc", 32'(acc), 32'd0);
        check_eq("t3_clear_ovf", 32'(overflow), 32'd0);
        check_eq("t3_clear_idle", 32'(busy), 32'd0);

        // 4: clear coinciding with transfer, then clear during MUL ignored
        run_op("t4a", 8'd100, 8'd10, 1'b0, 1'b0, 1'b0, 16'd1000, 1'b0);
        run_op("t4b", 8'd16, 8'd16, 1'b1, 1'b0, 1'b0, 16'd256, 1'b0);
        run_op("t4c", 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 16'd256, 1'b0);

        // 5: zero multiplicand, in_valid held through busy
        run_op("t5a", 8'd7, 8'd11, 1'b1, 1'b0, 1'b0, 16'd77, 1'b0);
        run_op("t5b", 8'd0, 8'd200, 1'b0, 1'b1, 1'b0, 16'd77, 1'b0);
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            if (out_valid === 1'b1 || busy === 1'b1) pulses++;
            tick();
        end
        check_eq("t5_no_extra_op", 32'(pulses), 32'd0);

        // 6: async reset in MUL cycle 4
        a        = 8'd9;
        b        = 8'd9;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        check_eq("t6_busy_mul", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("t6_rst_acc", 32'(acc), 32'd0);
        check_eq("t6_rst_busy", 32'(busy), 32'd0);
        tick();
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            if (out_valid === 1'b1) pulses++;
            tick();
        end
        check_eq("t6_no_out_valid", 32'(pulses), 32'd0);
        check_eq("t6_ready", 32'(in_ready), 32'd1);
        run_op("t6b", 8'd2, 8'd3, 1'b0, 1'b0, 1'b0, 16'd6, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
